// File: rtl/xram_resp.sv
// xram_resp: 8051 XRAM responder with wait states,
// write-protect window and protocol checking.
module xram_resp #(
  parameter int          DEPTH       = 65536,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] WP_START    = 16'h0000,
  parameter logic [15:0] WP_END      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        wr,
  input  logic        stb,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        ack,
  output logic [1:0]  xresp_state,
  output logic        wp_err,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ACK  = 2'b10,
    S_BAD  = 2'b11
  } state_t;

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [3:0]  WS_M1   = 4'(WAIT_STATES - 1);
  localparam logic [15:0] WP_SPAN = WP_END - WP_START;

  logic [7:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic        wp_err_q, wp_err_d;
  logic        proto_q, proto_d;
  logic [7:0]  dout_q, dout_d;

  logic [15:0] rd_addr;
  logic        rd_wr;
  logic        mismatch;
  logic        wr_en;

  function automatic logic in_range(input logic [15:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Window test via offset so an empty window never matches.
  function automatic logic wp_hit(input logic [15:0] a);
    logic [15:0] off;
    off = a - WP_START;
    return off < WP_SPAN;
  endfunction

  // In IDLE the live bus is the request; afterwards the latch is.
  assign rd_addr  = (state_q == S_IDLE) ? addr : addr_q;
  assign rd_wr    = (state_q == S_IDLE) ? wr : wr_q;
  assign mismatch = stb && ((addr != addr_q) || (wr != wr_q));

  // Next-state, latch, counter and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    ack_d    = 1'b0;
    wp_err_d = 1'b0;
    proto_d  = proto_q;
    dout_d   = dout_q;
    unique case (state_q)
      S_IDLE: begin
        if (stb) begin
          addr_d  = addr;
          wr_d    = wr;
          cnt_d   = WS_M1;
          state_d = (WAIT_STATES == 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!stb) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
        if (mismatch) proto_d = 1'b1;
      end
      S_ACK: begin
        state_d = S_IDLE;
        if (mismatch) proto_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ACK && state_q != S_ACK) begin
      ack_d = 1'b1;
      if (!rd_wr) begin
        dout_d = in_range(rd_addr) ? mem[rd_addr[AW-1:0]] : 8'h00;
      end else if (in_range(rd_addr) && wp_hit(rd_addr)) begin
        wp_err_d = 1'b1;
      end
    end
  end

  // Late write commit at the edge leaving ACK.
  assign wr_en = rst && (state_q == S_ACK) && wr_q &&
                 in_range(addr_q) && !wp_hit(addr_q);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'h0000;
      wr_q     <= 1'b0;
      ack_q    <= 1'b0;
      wp_err_q <= 1'b0;
      proto_q  <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
      wp_err_q <= wp_err_d;
      proto_q  <= proto_d;
      dout_q   <= dout_d;
    end
  end

  // Backing store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr_q[AW-1:0]] <= data_in;
  end

  assign data_out    = dout_q;
  assign ack         = ack_q;
  assign xresp_state = state_q;
  assign wp_err      = wp_err_q;
  assign proto_err   = proto_q;

endmodule
